// File: rtl/uart_frame_master_if.sv
// rtl/uart_frame_master_if.sv - request/response handshake bundle for uart_frame_master
//
// Purpose: groups the word-level request and response signals of the UART
// frame master so they travel as one port.
// Signals:
//   req_data     request word, byte k = req_data[8k+7:8k]
//   req_valid    request offered by the host
//   req_ready    frame master can accept a request
//   rsp_data     last complete response word, byte k received k-th
//   rsp_valid    one-cycle pulse, rsp_data updated this cycle
//   rsp_timeout  one-cycle pulse, response collection aborted
// Modports:
//   master  host side (drives the request, observes the response)
//   slave   frame master side
interface uart_frame_master_if #(
  parameter int FRAME_BYTES = 8
);
  logic [8*FRAME_BYTES-1:0] req_data;
  logic                     req_valid;
  logic                     req_ready;
  logic [8*FRAME_BYTES-1:0] rsp_data;
  logic                     rsp_valid;
  logic                     rsp_timeout;

  modport master (
    output req_data, req_valid,
    input  req_ready, rsp_data, rsp_valid, rsp_timeout
  );

  modport slave (
    input  req_data, req_valid,
    output req_ready, rsp_data, rsp_valid, rsp_timeout
  );
endinterface

// File: rtl/uart_frame_master.sv
// rtl/uart_frame_master.sv - host-side UART 8N1 frame master with strobe and response timeout
//
// Purpose: sends one request word as FRAME_BYTES UART bytes (LSB byte first),
// pulses frame_strobe to the peer, then collects FRAME_BYTES response bytes
// into one word, aborting if the line stays quiet for TIMEOUT_CYCLES.
// Ports:
//   clk, reset    system clock, synchronous active-high reset
//   bus           request/response handshake (uart_frame_master_if.slave)
//   tx            UART transmit, idle high
//   rx            UART receive, asynchronous
//   frame_strobe  "frame complete" pulse to the peer
//   busy          high in any state other than IDLE
//   rx_frame_err  one-cycle pulse, received byte had stop bit = 0
module uart_frame_master #(
  parameter int CLKS_PER_BIT   = 894,
  parameter int FRAME_BYTES    = 8,
  parameter int STROBE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_frame_master_if.slave   bus,
  output logic                 tx,
  input  logic                 rx,
  output logic                 frame_strobe,
  output logic                 busy,
  output logic                 rx_frame_err
);
  localparam int W  = 8 * FRAME_BYTES;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(FRAME_BYTES) + 1;

  localparam logic [CW-1:0] CPB_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] FB_N      = BW'(FRAME_BYTES);
  localparam logic [BW-1:0] FB_LAST   = BW'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, TX, STROBE, WAIT_RSP} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t          state;
  logic            req_ready_q, rsp_valid_q, rsp_timeout_q;
  logic [W-1:0]    rsp_data_q, staging, tx_word;
  logic [7:0]      tx_byte;
  logic [CW-1:0]   bit_cnt;
  logic [3:0]      bit_idx;
  logic [BW-1:0]   byte_idx, rx_count, rx_count_nxt;
  logic [SW-1:0]   stb_cnt;
  logic [TW-1:0]   to_cnt;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_prev, rx_done;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bit;
  logic [7:0]      rx_shift, rx_byte;

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign rx_count_nxt    = rx_count + BW'(1);

  // Receiver runs regardless of the frame state; it only produces byte-done
  // and framing-error events, which the main FSM filters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= rx;
      rx_s2        <= rx_s1;
      rx_prev      <= rx_s2;
      rx_done      <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Half a bit after the edge: a high line means a glitch, not a start bit.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == CPB_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == CPB_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) begin
              rx_done <= 1'b1;
              rx_byte <= rx_shift;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      tx            <= 1'b1;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_data_q    <= '0;
      frame_strobe  <= 1'b0;
      busy          <= 1'b0;
      staging       <= '0;
      tx_word       <= '0;
      tx_byte       <= '0;
      bit_cnt       <= '0;
      bit_idx       <= '0;
      byte_idx      <= '0;
      rx_count      <= '0;
      stb_cnt       <= '0;
      to_cnt        <= '0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          req_ready_q <= 1'b1;
          busy        <= 1'b0;
          tx          <= 1'b1;
          if (bus.req_valid && req_ready_q) begin
            state       <= TX;
            req_ready_q <= 1'b0;
            busy        <= 1'b1;
            tx          <= 1'b0;
            tx_byte     <= bus.req_data[7:0];
            tx_word     <= bus.req_data >> 8;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            byte_idx    <= '0;
          end
        end
        TX: begin
          // bit_idx: 0 = start, 1..8 = data, 9 = stop; tx is loaded one bit ahead.
          if (bit_cnt == CPB_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == 4'd9) begin
              bit_idx <= '0;
              if (byte_idx == FB_LAST) begin
                state        <= STROBE;
                tx           <= 1'b1;
                frame_strobe <= 1'b1;
                stb_cnt      <= '0;
              end else begin
                byte_idx <= byte_idx + BW'(1);
                tx       <= 1'b0;
                tx_byte  <= tx_word[7:0];
                tx_word  <= tx_word >> 8;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= (bit_idx == 4'd8) ? 1'b1 : tx_byte[bit_idx[2:0]];
            end
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        STROBE: begin
          if (stb_cnt == STB_LAST) begin
            frame_strobe <= 1'b0;
            state        <= WAIT_RSP;
            rx_count     <= '0;
            to_cnt       <= '0;
            staging      <= '0;
          end else begin
            stb_cnt <= stb_cnt + SW'(1);
          end
        end
        WAIT_RSP: begin
          // Bytes shift in from the top so the first byte lands in the low lane.
          if (rx_done) begin
            to_cnt   <= '0;
            staging  <= {rx_byte, staging[W-1:8]};
            rx_count <= rx_count_nxt;
            if (rx_count_nxt == FB_N) begin
              rsp_data_q  <= {rx_byte, staging[W-1:8]};
              rsp_valid_q <= 1'b1;
              state       <= IDLE;
              req_ready_q <= 1'b1;
              busy        <= 1'b0;
            end
          end else if (to_cnt == TO_LAST) begin
            rsp_timeout_q <= 1'b1;
            state         <= IDLE;
            req_ready_q   <= 1'b1;
            busy          <= 1'b0;
            staging       <= '0;
            rx_count      <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_frame_master.sv
// tb/tb_uart_frame_master.sv - scoreboard bench for uart_frame_master
module tb_uart_frame_master;
  localparam int CPB      = 4;
  localparam int FB       = 8;
  localparam int STB      = 4;
  localparam int TO       = 200;
  localparam int BYTE_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic tx, frame_strobe, busy, rx_frame_err;

  uart_frame_master_if #(.FRAME_BYTES(FB)) bus ();

  uart_frame_master #(
    .CLKS_PER_BIT(CPB), .FRAME_BYTES(FB), .STROBE_CYCLES(STB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .tx(tx), .rx(rx),
    .frame_strobe(frame_strobe), .busy(busy), .rx_frame_err(rx_frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_rsp = 0, n_to = 0, n_ferr = 0, n_strobe = 0;
  int to_cyc = 0, stop_end = 0;
  logic [7:0]  tx_q[$];
  logic [63:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Response scoreboard and pulse counters.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
        else check("rsp_data", bus.rsp_data, exp_q.pop_front());
      end
      if (bus.rsp_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
      if (rx_frame_err) n_ferr++;
      if (frame_strobe) n_strobe++;
    end
  end

  task automatic do_request(input logic [63:0] w);
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_data  = w;
    bus.req_valid = 1'b1;
    for (int i = 0; i < FB; i++) tx_q.push_back(w[8*i +: 8]);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_data  = {$urandom, $urandom};
  endtask

  // Cycle-exact check of the transmitted frame and the following strobe.
  task automatic check_tx_frame();
    logic [7:0] eb, got;
    logic       e;
    logic [5:0] stb;
    int errs, pos, bitn, rdy_hi, stb_hi, busy_lo;
    rdy_hi = 0; stb_hi = 0; busy_lo = 0; errs = 0; eb = '0; got = '0;
    for (int c = 0; c < FB * BYTE_CYC; c++) begin
      pos  = c % BYTE_CYC;
      bitn = pos / CPB;
      if (pos == 0) begin
        eb   = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
        errs = 0;
        got  = '0;
      end
      @(negedge clk);
      e = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : eb[bitn-1];
      if (tx !== e) errs++;
      if ((pos % CPB) == CPB / 2 && bitn >= 1 && bitn <= 8) got[bitn-1] = tx;
      if (bus.req_ready) rdy_hi++;
      if (frame_strobe) stb_hi++;
      if (!busy) busy_lo++;
      if (pos == BYTE_CYC - 1) begin
        check("tx_bit_errors", errs, 0);
        check("tx_byte", got, eb);
      end
    end
    check("req_ready_in_tx", rdy_hi, 0);
    check("strobe_in_tx", stb_hi, 0);
    check("busy_in_tx", busy_lo, 0);
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      stb[s] = frame_strobe;
    end
    check("strobe_shape", stb, 6'b001111);
  endtask

  task automatic uart_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    @(posedge clk);
    #1;
    uart_bit(1'b0);
    for (int i = 0; i < 8; i++) uart_bit(b[i]);
    uart_bit(stop);
    rx = 1'b1;
    stop_end = cyc;
  endtask

  task automatic send_frame(input logic [7:0] base);
    logic [63:0] w;
    for (int i = 0; i < FB; i++) w[8*i +: 8] = base + 8'(i);
    exp_q.push_back(w);
    for (int i = 0; i < FB; i++) uart_send(base + 8'(i), 1'b1);
  endtask

  task automatic wait_rsp(input int target);
    int k;
    k = 0;
    while (n_rsp < target && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rsp_arrived", n_rsp, target);
    @(negedge clk);
    check("req_ready_after_rsp", bus.req_ready, 1);
    check("busy_after_rsp", busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, strobe0;
    logic [63:0] w;
    bus.req_data  = '0;
    bus.req_valid = 1'b0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    check("reset_req_ready", bus.req_ready, 0);
    check("reset_tx", tx, 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_tx", tx, 1);
    check("idle_req_ready", bus.req_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_rsp_data", bus.rsp_data, 0);
    check("idle_strobe", frame_strobe, 0);

    // Full request and loopback response.
    do_request(64'h0807060504030201);
    check_tx_frame();
    send_frame(8'hA0);
    wait_rsp(1);

    // Short response: timeout after the third byte.
    do_request({$urandom, $urandom});
    check_tx_frame();
    for (int i = 0; i < 3; i++) uart_send(8'hC0 + 8'(i), 1'b1);
    k = 0;
    while (n_to < 1 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("timeout_pulsed", n_to, 1);
    check("timeout_not_early", (to_cyc - stop_end) >= TO, 1);
    check("timeout_not_late", (to_cyc - stop_end) <= TO + 4, 1);
    check("timeout_no_rsp", n_rsp, 1);
    check("timeout_rsp_kept", bus.rsp_data, 64'hA7A6A5A4A3A2A1A0);
    @(negedge clk);
    check("timeout_ready", bus.req_ready, 1);
    do_request({$urandom, $urandom});
    check_tx_frame();
    send_frame(8'hD0);
    wait_rsp(2);

    // Framing error then a one-cycle glitch; neither counts as a byte.
    do_request({$urandom, $urandom});
    check_tx_frame();
    uart_send(8'hE5, 1'b0);
    @(posedge clk); #1 rx = 1'b0;
    @(posedge clk); #1 rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("frame_err_once", n_ferr, 1);
    check("frame_err_no_rsp", n_rsp, 2);
    send_frame(8'h30);
    wait_rsp(3);
    check("frame_err_total", n_ferr, 1);

    // Reset in the middle of the third transmitted byte.
    w = {$urandom, $urandom};
    do_request(w);
    repeat (2 * BYTE_CYC + BYTE_CYC / 2) @(negedge clk);
    check("midtx_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_tx", tx, 1);
    check("reset_mid_busy", busy, 0);
    check("reset_mid_strobe", frame_strobe, 0);
    check("reset_mid_rsp_data", bus.rsp_data, 0);
    reset = 1'b0;
    tx_q.delete();
    strobe0 = n_strobe;
    repeat (FB * BYTE_CYC) @(negedge clk);
    check("no_strobe_after_reset", n_strobe, strobe0);
    do_request(64'h1122334455667788);
    check_tx_frame();
    send_frame(8'h50);
    wait_rsp(4);

    check("timeouts_total", n_to, 1);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
